mo_demont: RTL and testbench
============================

MO_DEMONT -- requirements
Module: mo_demont

Interface
REQ-001 SHALL take parameter Q, default 3329, as the modulus (prime, Q < 2^`MUL_STAGE_CNT).
REQ-002 SHALL take parameter SHIFT_CNT, default `MUL_STAGE_CNT (from mo_mul.svh), as the number of modular doublings applied.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL provide port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL provide port in_ready, output, 1 bit: block can accept in_data.
REQ-007 SHALL provide port in_data, input, signed `MUL_STAGE_CNT+1 bits: Montgomery-domain multiplier result, range -Q..Q inclusive.
REQ-008 SHALL provide port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL provide port out_ready, input, 1 bit: consumer accepts out_data.
REQ-010 SHALL provide port out_data, output, unsigned `MUL_STAGE_CNT bits: (in_data * 2^SHIFT_CNT) mod Q, canonical range 0..Q-1.

Function
REQ-011 SHALL be an FSM with states IDLE, NORM, SHIFT and DONE; only one operand is in flight at a time.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready SHALL register in_data into acc and go to NORM.
REQ-013 NORM (1 cycle): acc<0 -> acc+Q; acc>=Q -> acc-Q; otherwise unchanged; step counter cleared; go to SHIFT.
REQ-014 SHIFT: per cycle acc=2*acc, then subtract Q if result >=Q; counter increments; after SHIFT_CNT steps go to DONE.
REQ-015 Internal acc SHALL be at least `MUL_STAGE_CNT+2 bits wide so that no intermediate overflows; invariant 0<=acc<Q holds after NORM.
REQ-016 DONE: out_valid=1, out_data=acc, held stable until out_ready=1; on out_valid&&out_ready go to IDLE.
REQ-017 in_ready SHALL be 0 in NORM, SHIFT and DONE; in_valid is ignored there.
REQ-018 Latency: out_valid SHALL rise SHIFT_CNT+1 rising edges after the accepting edge (default 13).
REQ-019 Throughput: next operand accepted no earlier than the edge after the DONE handshake; no IDLE bypass.
REQ-020 out_ready asserted before out_valid SHALL have no effect.
REQ-021 Inputs -Q and Q SHALL yield out_data 0.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, acc=0, counter=0, out_valid=0, out_data=0, in_ready=1 after release.
REQ-023 rst asserted mid-operation SHALL discard the operand in flight; no out_valid pulse follows release.

Configuration
REQ-024 Macro MO_DEMONT_2BIT_EN defined: SHIFT performs two doublings per cycle (each followed by conditional subtract of Q); odd SHIFT_CNT final cycle performs one; latency ceil(SHIFT_CNT/2)+1 edges (default 7).
REQ-025 MO_DEMONT_2BIT_EN undefined: one doubling per cycle per REQ-014/REQ-018; results bit-identical in both builds.

Verification (Q=3329, SHIFT_CNT=12)
REQ-026 in_data=1, out_ready=1 -> out_data=767, out_valid 13 edges after accept (7 with MO_DEMONT_2BIT_EN).
REQ-027 in_data=-1 -> 2562; in_data=0 -> 0; in_data=3329 -> 0; in_data=-3329 -> 0.
REQ-028 Result 767 with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; accepted on out_ready=1, then in_ready=1 the next cycle.
REQ-029 rst pulsed during SHIFT step 6 -> out_valid stays 0, in_ready=1 after release; new in_data=2 -> 1534.
REQ-030 1000 random in_data in -Q..Q with random out_ready stalls -> every out_data equals (in_data*4096) mod 3329, in order, none dropped or duplicated.

Source files
------------

// File: rtl/mo_demont.sv
// rtl/mo_demont.sv - Montgomery-domain exit: (in_data * 2^SHIFT_CNT) mod Q by repeated modular doubling
//
// Purpose: normalises a signed multiplier result in -Q..Q into 0..Q-1, then applies
//   SHIFT_CNT modular doublings. One operand is in flight at a time.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - in_data valid
//   in_ready   - block accepts an operand (IDLE only)
//   in_data    - signed `MUL_STAGE_CNT+1 bit operand, range -Q..Q
//   out_valid  - out_data valid (DONE only)
//   out_ready  - consumer accepts out_data
//   out_data   - unsigned `MUL_STAGE_CNT bit result, 0..Q-1
// Configuration: define MO_DEMONT_2BIT_EN for two doublings per SHIFT cycle.

`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 12
`endif

module mo_demont #(
  parameter int Q         = 3329,
  parameter int SHIFT_CNT = `MUL_STAGE_CNT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [`MUL_STAGE_CNT:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`MUL_STAGE_CNT-1:0]   out_data
);

  localparam int W  = `MUL_STAGE_CNT;
  // Two guard bits: one for the sign, one so 2*acc (< 2Q) never overflows.
  localparam int AW = W + 2;
  localparam int CW = $clog2(SHIFT_CNT + 2);
  localparam logic signed [AW-1:0] QA = AW'(Q);

  typedef enum logic [1:0] {IDLE, NORM, SHIFT, DONE} state_t;

  state_t                 state, state_next;
  logic signed [AW-1:0]   acc, acc_next;
  logic [CW-1:0]          cnt, cnt_next;

  // One modular doubling; input is already in 0..Q-1 so one subtract suffices.
  function automatic logic signed [AW-1:0] dbl_mod(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] t;
    t = a <<< 1;
    if (t >= QA) t = t - QA;
    return t;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next   = {in_data[W], in_data};
          state_next = NORM;
        end
      end
      NORM: begin
        if (acc < 0)        acc_next = acc + QA;
        else if (acc >= QA) acc_next = acc - QA;
        cnt_next   = '0;
        state_next = (SHIFT_CNT == 0) ? DONE : SHIFT;
      end
      SHIFT: begin
`ifdef MO_DEMONT_2BIT_EN
        // Odd SHIFT_CNT: the final cycle falls back to a single doubling.
        if (int'(cnt) + 2 <= SHIFT_CNT) begin
          acc_next = dbl_mod(dbl_mod(acc));
          cnt_next = cnt + CW'(2);
        end else begin
          acc_next = dbl_mod(acc);
          cnt_next = cnt + CW'(1);
        end
`else
        acc_next = dbl_mod(acc);
        cnt_next = cnt + CW'(1);
`endif
        if (int'(cnt_next) >= SHIFT_CNT) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_data = acc[W-1:0];

endmodule

// File: tb/tb_mo_demont.sv
// tb/tb_mo_demont.sv - self-checking bench for mo_demont
`timescale 1ns/1ps

module tb_mo_demont;

  localparam int W = 12;
  localparam int Q = 3329;
`ifdef MO_DEMONT_2BIT_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 13;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;

  int n_cmp = 0;
  int n_bad = 0;

  mo_demont #(.Q(Q), .SHIFT_CNT(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int exp;
    int stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Runs one operand; called #1 after a rising edge. Holds in_valid high with
  // junk data while busy to show it is ignored.
  task automatic do_op(input int x, input int stall, output int res, output int lat,
                       input bit chk_lat, input bit chk_stall);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (guard >= 100) check("wait_in_ready", 0, 1);
    in_valid = 1'b1;
    in_data  = (W+1)'(x);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = (W+1)'(17);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) check("wait_out_valid", 0, 1);
    res = int'(out_data);
    if (chk_lat) check("latency", lat, LAT);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (chk_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), res);
        check("stall_in_ready", int'(in_ready), 0);
      end else if (!out_valid || int'(out_data) != res) begin
        check("stall_hold", 0, 1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (chk_stall) begin
      check("post_hs_valid", int'(out_valid), 0);
      check("post_hs_in_ready", int'(in_ready), 1);
    end
  endtask

  initial begin
    int res, lat, x, m, guard;
    vecs.push_back('{1, 767, 0});
    vecs.push_back('{-1, 2562, 0});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{3329, 0, 0});
    vecs.push_back('{-3329, 0, 0});
    vecs.push_back('{2, 1534, 1});
    vecs.push_back('{3328, 2562, 0});
    vecs.push_back('{-3328, 767, 2});
    vecs.push_back('{5, 506, 0});
    vecs.push_back('{100, 133, 0});
    vecs.push_back('{-100, 3196, 3});
    vecs.push_back('{1665, 2048, 0});
    vecs.push_back('{-1665, 1281, 0});
    vecs.push_back('{3, 2301, 0});
    vecs.push_back('{4, 3068, 0});

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);

    // out_ready high while idle must not matter
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("early_ready_valid", int'(out_valid), 0);
    out_ready = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].x, vecs[i].stall, res, lat, 1'b1, 1'b0);
      check($sformatf("vec%0d_x%0d", i, vecs[i].x), res, vecs[i].exp);
    end

    // 767 held for 5 stalled cycles
    do_op(1, 5, res, lat, 1'b1, 1'b1);
    check("stall_result", res, 767);

    // reset during shift step 6
    in_valid = 1'b1; in_data = (W+1)'(1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    guard = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (out_valid) guard++; end
    check("midrst_no_pulse", guard, 0);
    do_op(2, 0, res, lat, 1'b1, 1'b0);
    check("after_rst_x2", res, 1534);

    // random operands with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(0, 2*Q)) - Q;
      m = (((x % Q) + Q) % Q) * 4096 % Q;
      do_op(x, int'($urandom_range(0, 3)), res, lat, 1'b0, 1'b0);
      check($sformatf("rand%0d_x%0d", i, x), res, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
